tim_capture_bank: RTL

//  Multi-channel input-capture unit for the general-purpose timer. Replaces the single-channel capture path.
//  Per channel: input synchroniser, fDTS-sampled digital filter, polarity/edge select, input mux and event prescaler.

---
 rtl/tim_capture_bank.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/tim_capture_bank.sv
// Multi-channel input-capture bank: per-channel synchroniser, fDTS filter, edge/source select,
// event prescaler and capture register with sticky capture/overcapture flags.
module tim_capture_bank #(
  parameter int NUM_CH    = 4,
  parameter int CNT_WIDTH = 16,
  parameter int FILT_W    = 4
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [1:0]                  ckd_i,
  input  logic [CNT_WIDTH-1:0]        cnt_i,
  input  logic [NUM_CH-1:0]           ti_i,
  input  logic                        trc_i,
  input  logic [2*NUM_CH-1:0]         ccs_i,
  input  logic [FILT_W*NUM_CH-1:0]    icf_i,
  input  logic [2*NUM_CH-1:0]         icps_i,
  input  logic [NUM_CH-1:0]           ccp_i,
  input  logic [NUM_CH-1:0]           ccnp_i,
  input  logic [NUM_CH-1:0]           cce_i,
  input  logic [NUM_CH-1:0]           ccif_clr_i,
  input  logic [NUM_CH-1:0]           ccof_clr_i,
  output logic [NUM_CH-1:0]           tif_o,
  output logic [CNT_WIDTH*NUM_CH-1:0] ccr_o,
  output logic [NUM_CH-1:0]           ccif_o,
  output logic [NUM_CH-1:0]           ccof_o,
  output logic [NUM_CH-1:0]           cap_evt_o
);

  logic [1:0]        r_dts_cnt;
  logic              w_tick;
  logic              r_trc_q;
  logic              r_trc_d;
  logic              w_trc_rise;
  logic [NUM_CH-1:0] w_rise;
  logic [NUM_CH-1:0] w_fall;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_dts_cnt <= '0;
      r_trc_q   <= 1'b0;
      r_trc_d   <= 1'b0;
    end else begin
      r_dts_cnt <= r_dts_cnt + 2'd1;
      r_trc_q   <= trc_i;
      r_trc_d   <= r_trc_q;
    end
  end

  assign w_tick     = (ckd_i == 2'b00) ? 1'b1 :
                      (ckd_i == 2'b01) ? r_dts_cnt[0] : (&r_dts_cnt);
  assign w_trc_rise = r_trc_q & ~r_trc_d;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    localparam int PAIR = g ^ 1;

    logic                 r_sync1, r_sync2, r_tif, r_tif_d;
    logic [FILT_W-1:0]    r_filt_cnt;
    logic [2:0]           r_psc_cnt;
    logic [1:0]           r_icps_d;
    logic [CNT_WIDTH-1:0] r_ccr;
    logic                 r_ccif, r_ccof, r_cap_evt;

    logic [1:0]        w_ccs, w_icps;
    logic [FILT_W-1:0] w_icf;
    logic [FILT_W:0]   w_cnt_inc;
    logic              w_filt_done;
    logic              w_rise_sel, w_fall_sel, w_pol_evt, w_evt;
    logic [2:0]        w_psc_top;
    logic              w_icps_chg, w_cap;

    assign w_ccs       = ccs_i[2*g +: 2];
    assign w_icps      = icps_i[2*g +: 2];
    assign w_icf       = icf_i[FILT_W*g +: FILT_W];
    assign w_cnt_inc   = {1'b0, r_filt_cnt} + (FILT_W+1)'(1);
    assign w_filt_done = (w_cnt_inc >= {1'b0, w_icf});

    assign w_rise[g]  = r_tif & ~r_tif_d;
    assign w_fall[g]  = ~r_tif & r_tif_d;
    // Pair input keeps the partner's filter but applies this channel's polarity.
    assign w_rise_sel = (w_ccs == 2'b01) ? w_rise[PAIR] : w_rise[g];
    assign w_fall_sel = (w_ccs == 2'b01) ? w_fall[PAIR] : w_fall[g];

    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    always_comb begin
      w_pol_evt = w_rise_sel;
      case ({ccp_i[g], ccnp_i[g]})
        2'b10:   w_pol_evt = w_fall_sel;
        2'b11:   w_pol_evt = w_rise_sel | w_fall_sel;
        default: w_pol_evt = w_rise_sel;
      endcase
      w_evt = 1'b0;
      case (w_ccs)
        2'b00, 2'b01: w_evt = w_pol_evt;
        2'b10:        w_evt = w_trc_rise;
        default:      w_evt = 1'b0;
      endcase
      w_psc_top = 3'd0;
      case (w_icps)
        2'b01:   w_psc_top = 3'd1;
        2'b10:   w_psc_top = 3'd3;
        2'b11:   w_psc_top = 3'd7;
        default: w_psc_top = 3'd0;
      endcase
    end

    assign w_icps_chg = (w_icps != r_icps_d);
    assign w_cap      = cce_i[g] & w_evt & ~w_icps_chg & (r_psc_cnt == w_psc_top);

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        r_sync1    <= 1'b0;
        r_sync2    <= 1'b0;
        r_tif      <= 1'b0;
        r_tif_d    <= 1'b0;
        r_filt_cnt <= '0;
      end else begin
        r_sync1 <= ti_i[g];
        r_sync2 <= r_sync1;
        r_tif_d <= r_tif;
        if (w_tick) begin
          if (w_icf == '0) begin
            r_tif      <= r_sync2;
            r_filt_cnt <= '0;
          end else if (r_sync2 == r_tif) begin
            r_filt_cnt <= '0;
          end else if (w_filt_done) begin
            r_tif      <= r_sync2;
            r_filt_cnt <= '0;
          end else begin
            r_filt_cnt <= r_filt_cnt + 1'b1;
          end
        end
      end
    end

    // NOTE: capture registers are reset with the rest of the state so ccr_o reads 0 after reset.
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        r_icps_d  <= '0;
        r_psc_cnt <= '0;
        r_ccr     <= '0;
        r_ccif    <= 1'b0;
        r_ccof    <= 1'b0;
        r_cap_evt <= 1'b0;
      end else begin
        r_icps_d  <= w_icps;
        r_cap_evt <= w_cap;
        if (!cce_i[g] || w_icps_chg) begin
          r_psc_cnt <= '0;
        end else if (w_evt) begin
          r_psc_cnt <= (r_psc_cnt == w_psc_top) ? 3'd0 : r_psc_cnt + 3'd1;
        end
        // A capture dominates a same-cycle flag clear; overcapture set dominates its clear.
        if (w_cap) begin
          r_ccr  <= cnt_i;
          r_ccif <= 1'b1;
          if (r_ccif && !ccif_clr_i[g]) r_ccof <= 1'b1;
          else if (ccof_clr_i[g])       r_ccof <= 1'b0;
        end else begin
          if (ccif_clr_i[g]) r_ccif <= 1'b0;
          if (ccof_clr_i[g]) r_ccof <= 1'b0;
        end
      end
    end

    assign tif_o[g]                          = r_tif;
    assign ccr_o[CNT_WIDTH*g +: CNT_WIDTH]   = r_ccr;
    assign ccif_o[g]                         = r_ccif;
    assign ccof_o[g]                         = r_ccof;
    assign cap_evt_o[g]                      = r_cap_evt;
  end

endmodule
